rv32_addsub_arbiter: RTL and testbench
======================================

# rv32_addsub_arbiter

Shares one 32-bit add/sub unit among `NUM_REQ` requesters in the RV32 execute stage (e.g. ALU ops, AUIPC/branch-target, load/store address generation). The block grants one requester per cycle round-robin. It drives the shared unit and registers the result with the requester ID into a single-entry output stage under valid/ready back-pressure. Latency is one cycle and throughput is one operation per cycle.

## Interface
Parameters:
- `NUM_REQ`, default 3: number of requesters, 2..8.
- `ID_W`, default `$clog2(NUM_REQ)`: requester-ID width; derived, do not override.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `[NUM_REQ]`: request pending, one bit per requester.
- `req_ready`, out, `[NUM_REQ]`: request accepted this cycle (one-hot or zero).
- `req_opsel`, in, `[NUM_REQ][4]`: operation select per requester.
- `req_opa`, in, `[NUM_REQ][32]`: operand A per requester.
- `req_opb`, in, `[NUM_REQ][32]`: operand B per requester.
- `rsp_valid`, out, 1: output stage holds a result.
- `rsp_ready`, in, 1: consumer takes the result this cycle.
- `rsp_result`, out, 32: result.
- `rsp_id`, out, `ID_W`: index of the requester that produced the result.
- `rsp_illegal`, out, 1: `opsel` was neither an add nor a sub code; the result is 0.

## Operation
- Opsel decode:
  - add for codes 0, 7 and 15.
  - sub for codes 1 and 8.
  - any other code gives result 0 with `rsp_illegal`=1.
- Arithmetic is 32-bit modulo. Carry and borrow are discarded; there is no overflow flag.
- `accept` = `!rsp_valid || rsp_ready`.
- `grant` is one-hot over `req_valid`. The search starts at index `ptr+1` and wraps modulo `NUM_REQ`.
- `req_ready[i]` = `grant[i] && accept`. A transfer happens when `req_valid[i] && req_ready[i]`.
- `ready` may depend on `valid`. Requesters must not make `valid` depend on `ready`. Requesters must hold `opsel`/`opa`/`opb` stable while `valid && !ready`.
- `ptr` (an `ID_W`-bit register) updates to the granted index only on a transfer. With no transfer it holds.
- Output stage states:
  - EMPTY → FULL on a transfer.
  - FULL → EMPTY on `rsp_ready` with no new transfer.
  - FULL → FULL on `rsp_ready` plus a new transfer: the register is overwritten with the new result.
  - FULL with `!rsp_ready`: holds; `result`, `id` and `illegal` stay stable and all `req_ready` are 0.
- When no requester is valid, there is no grant and `ptr` holds.

## Timing
- Reset values: `rsp_valid`=0, `rsp_result`=0, `rsp_id`=0, `rsp_illegal`=0, `ptr`=`NUM_REQ-1`, so requester 0 wins first.
- `req_ready` is combinational; it is 0 during reset.
- A transfer in cycle N makes `rsp_valid`=1 in cycle N+1 with the registered result.
- Back-to-back: with `rsp_ready` held at 1, one transfer is made per cycle.
- Fairness: any continuously valid requester is granted within `NUM_REQ` transfers.
- Reset asserted mid-operation clears the output stage and `ptr` immediately. A pending result is lost. Requesters keep `valid` asserted and re-arbitrate after reset deasserts.
- Simultaneous consume and accept in the same cycle is legal; no bubble is inserted.

## Structure
- Package `rv32_alu_pkg` holds:
  - the opsel constants `ALU_ADD`=0, `ALU_SUB`=1, `ALU_ADD_PC`=7, `ALU_SUB_B`=8, `ALU_ADD_LS`=15;
  - the function `is_add(opsel)` / `is_sub(opsel)`.
- Sub-module `rv32_rr_arbiter`, parameterised by `NUM_REQ`. Inputs are `req` and `ptr`; output is the one-hot `grant` plus the encoded index. It is purely combinational.
- The top level instantiates the existing `rv32_alu_add_sub` unit on the muxed granted operands. The top level also owns the output register and `ptr`.

## Test plan
- Reset, then requester 1 only: `opsel`=0, A=`0x7FFFFFFF`, B=1. Expect `rsp_valid` the next cycle, result `0x80000000`, id 1, illegal 0.
- All three requesters valid continuously with `rsp_ready`=1. Expect grants in the order 0, 1, 2, 0, 1, 2…, one per cycle. With `opsel`=1, A=0, B=1, every result is `0xFFFFFFFF`.
- `rsp_ready`=0 for 3 cycles while FULL. Expect all `req_ready`=0 and the outputs stable. On `rsp_ready`=1, expect the next grant in the same cycle and the new result the following cycle.
- `opsel`=5 with A=5, B=3. Expect result 0 with `rsp_illegal`=1. Codes 7 and 15 give 8; code 8 gives 2.
- Assert `rst` mid-stream while FULL. Expect `rsp_valid` to drop immediately. After release, requester 0 is granted first.
- Random valid/ready stress with a scoreboard. Check:
  - every accepted request is returned exactly once, in acceptance order, with the correct id;
  - no requester waits more than `NUM_REQ` transfers.

Source files
------------

// File: rtl/rv32_addsub_arbiter_pkg.sv
// Opsel codes, output-stage states and the add/sub result bundle shared by
// the execute-stage add/sub arbiter.
package rv32_alu_pkg;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_ADD_PC = 4'd7;
  localparam logic [3:0] ALU_SUB_B  = 4'd8;
  localparam logic [3:0] ALU_ADD_LS = 4'd15;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        illegal;
  } alu_rsp_t;

  function automatic logic is_add(input logic [3:0] opsel);
    return (opsel == ALU_ADD) || (opsel == ALU_ADD_PC) || (opsel == ALU_ADD_LS);
  endfunction

  function automatic logic is_sub(input logic [3:0] opsel);
    return (opsel == ALU_SUB) || (opsel == ALU_SUB_B);
  endfunction

endpackage

// File: rtl/rv32_addsub_arbiter_if.sv
// Requester/response bundle of the shared add/sub unit; master = requesters
// plus consumer, slave = the arbiter.
interface rv32_addsub_arbiter_if #(parameter int NUM_REQ = 3);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0][3:0]  req_opsel;
  logic [NUM_REQ-1:0][31:0] req_opa;
  logic [NUM_REQ-1:0][31:0] req_opb;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [31:0]              rsp_result;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_illegal;

  modport master (
    output req_valid, req_opsel, req_opa, req_opb, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_id, rsp_illegal
  );

  modport slave (
    input  req_valid, req_opsel, req_opa, req_opb, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_id, rsp_illegal
  );
endinterface

// File: rtl/rv32_alu_add_sub.sv
// Shared 32-bit add/sub datapath; unknown opsel yields 0 and flags illegal.
module rv32_alu_add_sub
  import rv32_alu_pkg::*;
(
  input  logic [3:0]  opsel,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output alu_rsp_t    rsp
);
  always_comb begin
    rsp = '0;
    if (is_add(opsel))      rsp.result  = opa + opb;
    else if (is_sub(opsel)) rsp.result  = opa - opb;
    else                    rsp.illegal = 1'b1;
  end
endmodule

// File: rtl/rv32_rr_arbiter.sv
// Combinational round-robin pick: first requester after ptr, wrapping.
module rv32_rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx
);
  logic [ID_W-1:0] j;
  logic            found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = '0;
    // k = NUM_REQ lands back on ptr itself, so the last winner is checked last
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/rv32_addsub_arbiter.sv
// Round-robin sharing of one add/sub unit among NUM_REQ requesters, with a
// single-entry registered output stage under valid/ready back-pressure.
module rv32_addsub_arbiter
  import rv32_alu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic                  clk,
  input logic                  rst,
  rv32_addsub_arbiter_if.slave bus
);
  out_state_e         state, state_nxt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    gidx, ptr, id_q;
  logic               accept, xfer;
  alu_rsp_t           alu_out, rsp_q;

  rv32_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (bus.req_valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (gidx)
  );

  rv32_alu_add_sub u_alu (
    .opsel (bus.req_opsel[gidx]),
    .opa   (bus.req_opa[gidx]),
    .opb   (bus.req_opb[gidx]),
    .rsp   (alu_out)
  );

  // Consume and refill may coincide, so a full stage still accepts on rsp_ready
  assign accept        = (state == OUT_EMPTY) || bus.rsp_ready;
  assign bus.req_ready = (rst || !accept) ? '0 : grant;
  assign xfer          = |(bus.req_valid & bus.req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= OUT_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OUT_EMPTY: if (xfer) state_nxt = OUT_FULL;
      OUT_FULL:  if (bus.rsp_ready && !xfer) state_nxt = OUT_EMPTY;
    endcase
  end

  always_comb begin
    bus.rsp_valid = (state == OUT_FULL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_q <= '0;
      id_q  <= '0;
      ptr   <= ID_W'(NUM_REQ - 1);
    end else if (xfer) begin
      rsp_q <= alu_out;
      id_q  <= gidx;
      ptr   <= gidx;
    end
  end

  assign bus.rsp_result  = rsp_q.result;
  assign bus.rsp_illegal = rsp_q.illegal;
  assign bus.rsp_id      = id_q;
endmodule

// File: tb/tb_rv32_addsub_arbiter.sv
// Scoreboard bench for rv32_addsub_arbiter: directed scenarios then random
// valid/ready traffic against a queue-based reference model.
module tb_rv32_addsub_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_addsub_arbiter_if #(.NUM_REQ(N)) bus ();
  rv32_addsub_arbiter #(.NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic [31:0] res;
    int          id;
    bit          ill;
  } exp_t;

  exp_t           sbq[$];
  int             n_chk = 0;
  int             n_fail = 0;
  bit             m_full;
  int             m_last;
  logic [N-1:0]   xfer_vec = '0;
  int             wait_cnt[N];
  bit             prev_hold;
  logic [31:0]    prev_res;
  int             prev_id;
  bit             prev_ill;
  logic [3:0]     legal_ops[5] = '{4'd0, 4'd1, 4'd7, 4'd8, 4'd15};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: add codes 0/7/15, sub codes 1/8, all else illegal with 0
  function automatic exp_t ref_op(input logic [3:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int id);
    exp_t e;
    e.id  = id;
    e.ill = 1'b0;
    case (op)
      4'd0, 4'd7, 4'd15: e.res = a + b;
      4'd1, 4'd8:        e.res = a - b;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  // Model: round-robin grant after last winner, single-entry output occupancy
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    bit           acc;
    int           j;
    if (rst) begin
      m_full = 1'b0;
      m_last = N - 1;
      xfer_vec = '0;
      prev_hold = 1'b0;
      sbq.delete();
      foreach (wait_cnt[i]) wait_cnt[i] = 0;
    end else begin
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_full));
      if (prev_hold) begin
        chk("hold_result", 64'(bus.rsp_result), 64'(prev_res));
        chk("hold_id", 64'(bus.rsp_id), 64'(prev_id));
        chk("hold_illegal", 64'(bus.rsp_illegal), 64'(prev_ill));
      end
      acc = !m_full || bus.rsp_ready;
      exp_rdy = '0;
      j = 0;
      if (acc) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_last + k) % N;
          if (bus.req_valid[j]) begin exp_rdy[j] = 1'b1; break; end
        end
      end
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      xfer_vec = bus.req_valid & bus.req_ready;
      if (|exp_rdy) begin
        for (int i = 0; i < N; i++) if (exp_rdy[i]) j = i;
        sbq.push_back(ref_op(bus.req_opsel[j], bus.req_opa[j], bus.req_opb[j], j));
        for (int i = 0; i < N; i++) begin
          if (i == j || !bus.req_valid[i]) wait_cnt[i] = 0;
          else begin
            wait_cnt[i]++;
            chk("fair_wait", 64'(wait_cnt[i] <= N - 1), 64'd1);
          end
        end
        m_last = j;
        m_full = 1'b1;
      end else if (bus.rsp_ready) begin
        m_full = 1'b0;
      end
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      prev_res  = bus.rsp_result;
      prev_id   = int'(bus.rsp_id);
      prev_ill  = bus.rsp_illegal;
    end
  end

  // Monitor: every consumed response must match the oldest accepted request
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got response id %0d, expected none", bus.rsp_id);
      end else begin
        e = sbq.pop_front();
        chk("sb_result", 64'(bus.rsp_result), 64'(e.res));
        chk("sb_id", 64'(bus.rsp_id), 64'(e.id));
        chk("sb_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_all(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < N; i++) begin
      bus.req_opsel[i] = op;
      bus.req_opa[i]   = a;
      bus.req_opb[i]   = b;
    end
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) step();
  endtask

  initial begin
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    set_all(4'd0, 32'd0, 32'd0);

    // Reset state, with every requester already asking
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);

    // Requester 1 alone: signed-overflow wrap, one-cycle latency
    @(posedge clk); #1;
    rst = 1'b0;
    bus.req_valid = 3'b010;
    bus.req_opsel[1] = 4'd0;
    bus.req_opa[1] = 32'h7FFF_FFFF;
    bus.req_opb[1] = 32'd1;
    step();
    chk("single_valid", 64'(bus.rsp_valid), 64'd1);
    chk("single_result", 64'(bus.rsp_result), 64'h8000_0000);
    chk("single_id", 64'(bus.rsp_id), 64'd1);
    chk("single_illegal", 64'(bus.rsp_illegal), 64'd0);

    // Back-to-back: rotation continues after requester 1
    bus.req_valid = '1;
    set_all(4'd1, 32'd0, 32'd1);
    for (int c = 0; c < 6; c++) begin
      step();
      chk("b2b_id", 64'(bus.rsp_id), 64'((c + 2) % N));
      chk("b2b_result", 64'(bus.rsp_result), 64'hFFFF_FFFF);
    end

    // Stall three cycles while full, then resume with requester 2
    bus.rsp_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("resume_grant", 64'(bus.req_ready), 64'b100);
    step();
    chk("resume_id", 64'(bus.rsp_id), 64'd2);
    idle();

    // Opsel decode: illegal 5, add codes 7/15, sub code 8
    set_all(4'd0, 32'd5, 32'd3);
    bus.req_opsel[0] = 4'd5;
    bus.req_opsel[1] = 4'd7;
    bus.req_opsel[2] = 4'd15;
    bus.req_valid = '1;
    repeat (3) step();
    idle();
    set_all(4'd8, 32'd5, 32'd3);
    bus.req_valid = 3'b001;
    step();
    chk("sub8_result", 64'(bus.rsp_result), 64'd2);
    idle();

    // Reset while full: output drops at once, requester 0 wins afterwards
    set_all(4'd0, 32'd10, 32'd20);
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_grant", 64'(bus.req_ready), 64'b001);
    step();
    idle();

    // Random traffic; pending requests keep their operands until accepted
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!(bus.req_valid[i] && !xfer_vec[i])) begin
          bus.req_valid[i] = ($urandom_range(0, 3) != 0);
          bus.req_opsel[i] = ($urandom_range(0, 3) != 0) ? legal_ops[$urandom_range(0, 4)]
                                                         : 4'($urandom_range(0, 15));
          bus.req_opa[i] = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
          bus.req_opb[i] = $urandom;
        end
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end

    idle();
    step();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
